// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM state type and default vectors for the program-counter unit.
package pc_pkg;

    // Fetch-control states: BOOT fetches the reset vector once, RUN is normal
    // sequential fetch, HALT freezes the PC and marks it unfetchable.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned PC_DEFAULT_STEP         = 4;
    localparam int unsigned PC_DEFAULT_RAS_DEPTH    = 4;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with a top pointer and an occupancy
// count. A push when full overwrites the oldest entry; a pop when empty is
// ignored. Push and pop together replace the top entry in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = PC_DEFAULT_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_eff;
    logic             full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign top   = mem_q[ptr_q];

    // Pointer/count update; the write slot is always ptr_d when pushing.
    always_comb begin
        pop_eff = pop && !empty;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (push && !pop_eff) begin
            ptr_d = ptr_q + 1'b1;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (!push && pop_eff) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Stack storage and bookkeeping registers; reset empties the stack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            if (push) begin
                mem_q[ptr_d] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: parametrised program counter for the instruction-fetch stage.
// Prioritised trap/branch/return redirects, stall, halt/resume, target
// alignment checking. Define PC_RAS_EN to build the return-address stack;
// without it ras_push/ras_pop are ignored and ras_empty is tied high.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = XLEN'(PC_DEFAULT_RESET_VECTOR),
    parameter logic [XLEN-1:0]  TRAP_VECTOR  = XLEN'(PC_DEFAULT_TRAP_VECTOR),
    parameter int unsigned      STEP         = PC_DEFAULT_STEP,
    parameter int unsigned      RAS_DEPTH    = PC_DEFAULT_RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            trap,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            halted,
    output logic            ras_empty
);

    localparam logic [XLEN-1:0] STEP_X     = XLEN'(STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_seq;
    logic            misaligned_q, misaligned_d;
    logic            pc_valid_q, halted_q;
    logic            target_ok;
    logic            push_en, pop_en;
    logic [XLEN-1:0] ras_top_w;
    logic            ras_empty_w;

    assign pc_seq    = pc_q + STEP_X;
    assign target_ok = ((redirect_target & ALIGN_MASK) == '0);

    assign pc         = pc_q;
    assign pc_valid   = pc_valid_q;
    assign misaligned = misaligned_q;
    assign halted     = halted_q;
    assign ras_empty  = ras_empty_w;

    // Next-PC selection and state transitions.
    // The pop is consumed only when it actually selects the next PC; the push
    // goes with any non-stalled update, so trap and rejected redirects still push.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = 1'b0;
        push_en      = 1'b0;
        pop_en       = 1'b0;
        case (state_q)
            BOOT, RUN: begin
                if (trap) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = RUN;
                    push_en = ras_push;
                end else if (state_q == RUN && halt_req) begin
                    state_d = HALT;
                end else if (redirect) begin
                    state_d = RUN;
                    push_en = ras_push;
                    if (target_ok) begin
                        pc_d = redirect_target;
                    end else begin
                        misaligned_d = 1'b1;
                        pc_d         = stall ? pc_q : pc_seq;
                    end
                end else if (ras_pop && !ras_empty_w) begin
                    pc_d    = ras_top_w;
                    state_d = RUN;
                    pop_en  = 1'b1;
                    push_en = ras_push;
                end else if (!stall) begin
                    push_en = ras_push;
                    if (state_q == RUN) begin
                        pc_d = pc_seq;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                if (trap) begin
                    pc_d    = TRAP_VECTOR;
                    state_d = RUN;
                end else if (resume) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    // State, PC and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
            pc_valid_q   <= 1'b1;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
            pc_valid_q   <= (state_d != HALT);
            halted_q     <= (state_d == HALT);
        end
    end

`ifdef PC_RAS_EN
    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push_en),
        .pop       (pop_en),
        .push_data (pc_seq),
        .top       (ras_top_w),
        .empty     (ras_empty_w)
    );
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ras;
    assign ras_top_w   = '0;
    assign ras_empty_w = 1'b1;
    assign unused_ras  = push_en ^ pop_en;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scenarios plus randomized stimulus against a
// behavioural model of the program-counter unit.
`timescale 1ns/1ps
module tb_pc_unit;

    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] RV    = 32'h0000_0000;
    localparam logic [31:0] TV    = 32'h0000_0100;
    localparam int unsigned STEP  = 4;
    localparam int unsigned DEPTH = 2;
`ifdef PC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, halt_req = 1'b0, resume = 1'b0, trap = 1'b0;
    logic        redirect = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
    logic [31:0] redirect_target = '0;
    logic [31:0] pc;
    logic        pc_valid, misaligned, halted, ras_empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RV),
        .TRAP_VECTOR  (TV),
        .STEP         (STEP),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .halt_req        (halt_req),
        .resume          (resume),
        .trap            (trap),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .ras_push        (ras_push),
        .ras_pop         (ras_pop),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .misaligned      (misaligned),
        .halted          (halted),
        .ras_empty       (ras_empty)
    );

    // Behavioural model: fetch address, boot/halt flags, return stack as a queue.
    logic [31:0] m_pc;
    bit          m_boot, m_halted, m_mis;
    logic [31:0] m_ras[$];

    task automatic model_reset();
        m_pc = RV; m_boot = 1; m_halted = 0; m_mis = 0;
        m_ras.delete();
    endtask

    task automatic model_step();
        logic [31:0] ret;
        bit do_push;
        ret = m_pc + STEP;
        do_push = 0;
        m_mis = 0;
        if (m_halted) begin
            if (trap) begin m_pc = TV; m_halted = 0; end
            else if (resume) m_halted = 0;
        end else if (trap) begin
            m_pc = TV; m_boot = 0; do_push = ras_push;
        end else if (!m_boot && halt_req) begin
            m_halted = 1;
        end else if (redirect) begin
            m_boot = 0; do_push = ras_push;
            if (redirect_target % STEP == 0) m_pc = redirect_target;
            else begin m_mis = 1; if (!stall) m_pc = ret; end
        end else if (RAS_ON && ras_pop && m_ras.size() > 0) begin
            m_pc = m_ras.pop_back(); m_boot = 0; do_push = ras_push;
        end else if (!stall) begin
            do_push = ras_push;
            if (m_boot) m_boot = 0; else m_pc = ret;
        end
        if (RAS_ON && do_push) begin
            m_ras.push_back(ret);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
    endtask

    task automatic idle();
        stall = 0; halt_req = 0; resume = 0; trap = 0;
        redirect = 0; redirect_target = '0; ras_push = 0; ras_pop = 0;
    endtask

    // Advance one clock: model consumes the current inputs, DUT samples them.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #7;
        checks++; if (pc !== RV) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RV); end
        checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b want 1", pc_valid); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", misaligned); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL reset_ras_empty got %b want 1", ras_empty); end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_boot();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8;
        idle();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL boot_pc0 got %h want 0", pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== exp_seq[i]) begin errors++; $display("FAIL boot_pc%0d got %h want %h", i + 1, pc, exp_seq[i]); end
            checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL boot_valid%0d got %b want 1", i + 1, pc_valid); end
        end
    endtask

    task automatic test_priority();
        redirect = 1; redirect_target = 32'h40; tick(); idle();
        checks++; if (pc !== 32'h40) begin errors++; $display("FAIL prio_setup got %h want 40", pc); end
        trap = 1; redirect = 1; redirect_target = 32'h80; stall = 1; tick(); idle();
        checks++; if (pc !== 32'h100) begin errors++; $display("FAIL prio_trap got %h want 100", pc); end
        redirect = 1; redirect_target = 32'h80; tick(); idle();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL prio_redirect got %h want 80", pc); end
        stall = 1; tick(); idle();
        checks++; if (pc !== 32'h80) begin errors++; $display("FAIL prio_stall got %h want 80", pc); end
    endtask

    task automatic test_misaligned();
        redirect = 1; redirect_target = 32'h20; tick(); idle();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL mis_setup got %h want 20", pc); end
        redirect = 1; redirect_target = 32'h32; tick(); idle();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL mis_pc got %h want 24", pc); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b want 1", misaligned); end
        tick();
        checks++; if (pc !== 32'h28) begin errors++; $display("FAIL mis_next_pc got %h want 28", pc); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got %b want 0", misaligned); end
        redirect = 1; redirect_target = 32'h33; stall = 1; tick(); idle();
        checks++; if (pc !== 32'h28) begin errors++; $display("FAIL mis_stall_pc got %h want 28", pc); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL mis_stall_pulse got %b want 1", misaligned); end
    endtask

    task automatic test_halt();
        redirect = 1; redirect_target = 32'h10; tick(); idle();
        halt_req = 1; tick(); idle();
        for (int i = 0; i < 5; i++) begin
            checks++; if (pc !== 32'h10) begin errors++; $display("FAIL halt_pc%0d got %h want 10", i, pc); end
            checks++; if (halted !== 1'b1 || pc_valid !== 1'b0) begin
                errors++; $display("FAIL halt_flags%0d got halted=%b valid=%b want 1/0", i, halted, pc_valid);
            end
            redirect = 1; redirect_target = 32'h80; stall = i[0];
            if (i < 4) tick();
            idle();
        end
        resume = 1; tick(); idle();
        checks++; if (pc !== 32'h10 || pc_valid !== 1'b1 || halted !== 1'b0) begin
            errors++; $display("FAIL resume_pc got %h valid=%b halted=%b want 10/1/0", pc, pc_valid, halted);
        end
        tick();
        checks++; if (pc !== 32'h14) begin errors++; $display("FAIL resume_next got %h want 14", pc); end
        halt_req = 1; tick(); idle();
        trap = 1; tick(); idle();
        checks++; if (pc !== TV || halted !== 1'b0) begin
            errors++; $display("FAIL halt_trap got %h halted=%b want %h/0", pc, halted, TV);
        end
    endtask

    task automatic test_ras();
        rst = 1; #2; model_reset();
        @(posedge clk); #1; rst = 0;
        ras_push = 1; trap = 1; tick(); idle();
        checks++; if (pc !== 32'h100 || ras_empty !== 1'b0) begin
            errors++; $display("FAIL ras_push1 got %h empty=%b want 100/0", pc, ras_empty);
        end
        ras_push = 1; redirect = 1; redirect_target = 32'h200; tick(); idle();
        checks++; if (pc !== 32'h200) begin errors++; $display("FAIL ras_push2 got %h want 200", pc); end
        ras_push = 1; tick(); idle();
        checks++; if (pc !== 32'h204) begin errors++; $display("FAIL ras_push3 got %h want 204", pc); end
        ras_pop = 1; tick();
        checks++; if (pc !== 32'h204 || ras_empty !== 1'b0) begin
            errors++; $display("FAIL ras_pop1 got %h empty=%b want 204/0", pc, ras_empty);
        end
        tick();
        checks++; if (pc !== 32'h104 || ras_empty !== 1'b1) begin
            errors++; $display("FAIL ras_pop2 got %h empty=%b want 104/1", pc, ras_empty);
        end
        tick(); idle();
        checks++; if (pc !== 32'h108) begin errors++; $display("FAIL ras_pop3 got %h want 108", pc); end
    endtask

    task automatic test_wrap_reset();
        redirect = 1; redirect_target = 32'hFFFF_FFFC; tick(); idle();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup got %h want fffffffc", pc); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h want 0", pc); end
        ras_push = 1; tick(); idle();
        checks++; if (pc !== 32'h4 || ras_empty !== !RAS_ON) begin
            errors++; $display("FAIL wrap_push got %h empty=%b want 4/%b", pc, ras_empty, !RAS_ON);
        end
        #2; rst = 1; #1;
        model_reset();
        checks++; if (pc !== RV) begin errors++; $display("FAIL async_rst_pc got %h want %h", pc, RV); end
        checks++; if (ras_empty !== 1'b1 || pc_valid !== 1'b1 || halted !== 1'b0 || misaligned !== 1'b0) begin
            errors++; $display("FAIL async_rst_flags got empty=%b valid=%b halted=%b mis=%b want 1/1/0/0",
                               ras_empty, pc_valid, halted, misaligned);
        end
        @(posedge clk); #1; rst = 0;
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 800; i++) begin
            trap     = ($urandom_range(0, 15) == 0);
            halt_req = ($urandom_range(0, 11) == 0);
            resume   = ($urandom_range(0, 2) == 0);
            redirect = ($urandom_range(0, 3) == 0);
            stall    = ($urandom_range(0, 7) == 0);
            ras_push = ($urandom_range(0, 3) == 0);
            ras_pop  = ($urandom_range(0, 3) == 0);
            t = $urandom();
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            redirect_target = t;
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
            checks++; if (pc_valid !== !m_halted) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %b", i, pc_valid, !m_halted); end
            checks++; if (halted !== m_halted) begin errors++; $display("FAIL rnd_halted cyc %0d got %b want %b", i, halted, m_halted); end
            checks++; if (misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis cyc %0d got %b want %b", i, misaligned, m_mis); end
            checks++; if (ras_empty !== (m_ras.size() == 0)) begin
                errors++; $display("FAIL rnd_ras_empty cyc %0d got %b want %b", i, ras_empty, m_ras.size() == 0);
            end
        end
        idle();
    endtask

    initial begin
        model_reset();
        idle();
        test_reset();
        test_boot();
        test_priority();
        test_misaligned();
        test_halt();
`ifdef PC_RAS_EN
        test_ras();
`endif
        test_wrap_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the instruction-fetch stage. It replaces the fixed 32-bit PC register, and adds:

- a configurable width, reset vector and step;
- prioritised trap and branch redirects, stall and halt control;
- target-alignment checking;
- an optional return-address stack (RAS).

It drives the fetch address into instruction memory every cycle.

## Interface
- `XLEN`, 32: PC width in bits.
- `RESET_VECTOR`, 0: PC value loaded on reset.
- `TRAP_VECTOR`, 32'h0000_0100: PC value taken on a trap.
- `STEP`, 4: increment applied each sequential fetch. Must be a power of two.
- `RAS_DEPTH`, 4: number of RAS entries. Power of two, at least 2. Used only with `PC_RAS_EN`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous reset, active-high.
- `stall`  in  1: hold the PC.
- `halt_req`  in  1: enter the HALT state.
- `resume`  in  1: leave the HALT state.
- `trap`  in  1: redirect to `TRAP_VECTOR`.
- `redirect`  in  1: branch or jump taken.
- `redirect_target`  in  XLEN: branch or jump target.
- `ras_push`  in  1: call; push the return address (`pc + STEP`).
- `ras_pop`  in  1: return; redirect to the top of the RAS.
- `pc`  out  XLEN: current fetch address.
- `pc_valid`  out  1: `pc` is a fetchable address this cycle.
- `misaligned`  out  1: one-cycle pulse for a rejected target.
- `halted`  out  1: the unit is in HALT.
- `ras_empty`  out  1: the RAS holds no entries.

## Operation
- **States:**
  - `BOOT` is entered on reset. The first clock edge after reset keeps `pc = RESET_VECTOR` and moves to `RUN`, so `RESET_VECTOR` is fetched exactly once.
  - `RUN` is normal operation.
  - `HALT` freezes the PC.
- **Next-PC priority** (highest first) in `BOOT` and `RUN`:
  1. `trap`: load `TRAP_VECTOR`.
  2. `redirect`: load `redirect_target`.
  3. `ras_pop` when the RAS is non-empty: load the RAS top.
  4. `stall`: hold.
  5. Otherwise: `BOOT` holds; `RUN` loads `pc + STEP`.
- Any of trap, redirect or pop in `BOOT` leaves `BOOT` for `RUN` on the same edge. `stall` in `BOOT` keeps the state in `BOOT`.
- **Alignment:** a `redirect_target` with any of bits `[log2(STEP)-1:0]` set is rejected.
  - The PC loads `pc + STEP` instead, or holds if `stall` is asserted.
  - `misaligned` is 1 in the following cycle.
  - A trap is never checked for alignment.
- **HALT:**
  - `halt_req` in `RUN` moves to `HALT` on the next edge, unless `trap` is asserted that cycle.
  - In `HALT`, the PC holds and `pc_valid = 0`.
  - `resume` moves back to `RUN`, and the held PC is fetched again.
  - `trap` in `HALT` loads `TRAP_VECTOR` and moves to `RUN`.
  - `redirect` and RAS operations are ignored in `HALT`.
- **Arithmetic:** `pc + STEP` is computed modulo `2^XLEN`, so the PC wraps from all-ones to 0 silently.
- **Output values in each state:**
  - Reset: `pc = RESET_VECTOR`, `pc_valid = 1`, `misaligned = 0`, `halted = 0`, `ras_empty = 1`.
  - `BOOT` and `RUN`: `pc_valid = 1`.
  - `HALT`: `halted = 1`.

## Timing
- All outputs are registered. A redirect, trap or pop sampled at edge N appears on `pc` immediately after edge N, so the next-PC latency is 1 cycle.
- Reset is asynchronous: asserting `rst` mid-operation immediately forces all outputs to their reset values and empties the RAS.
- `ras_push` and `ras_pop` in the same cycle perform both operations: the pop reads the old top, and the push then overwrites that slot. The depth is unchanged.
- Push ordering against the PC update:
  - A push captures the pre-update `pc + STEP`.
  - A push is suppressed when `stall` wins the priority order, or in `HALT`.
  - With `trap` or a misaligned `redirect`, the push is still performed.

## Configuration
- **`PC_RAS_EN` defined:**
  - The RAS is built as a circular buffer of `RAS_DEPTH` entries with a top pointer and an occupancy count.
  - A push when full overwrites the oldest entry, and the count saturates at `RAS_DEPTH`.
  - A pop when empty is ignored and falls through to the lower priorities.
- **`PC_RAS_EN` not defined:**
  - The ports remain present.
  - `ras_push` and `ras_pop` are ignored.
  - `ras_empty` is tied to 1 and no RAS storage is built.

## Structure
- A shared package `pc_pkg` holds the FSM state enum (`BOOT`, `RUN`, `HALT`) and the default vector constants.
- The RAS is implemented as one sub-module, `pc_ras`, with ports `clk`, `rst`, `push`, `pop`, `push_data`, `top` and `empty`. It is instantiated only under `PC_RAS_EN`.

## Test plan
- **Boot hold:** release `rst` and run 3 cycles with defaults → `pc` = 0, 0, 4, 8. `pc_valid` = 1 throughout.
- **Priority:** in `RUN` at `pc` = 0x40, assert `trap` + `redirect` (target 0x80) + `stall` together → next `pc` = 0x100. Then `redirect` to 0x80 alone → `pc` = 0x80.
- **Misaligned target:** at `pc` = 0x20, `redirect` to 0x32 → `pc` = 0x24, and `misaligned` = 1 for exactly 1 cycle.
- **Halt and resume:** at `pc` = 0x10, assert `halt_req` → `pc` stays 0x10, `halted` = 1, `pc_valid` = 0 for 5 cycles. Then `resume` → `pc` = 0x10, 0x14.
- **RAS** (with `PC_RAS_EN`, `RAS_DEPTH` = 2): push at `pc` = 0x0, 0x100 and 0x200 (depth overflow), then pop 3 times → `pc` = 0x204, then 0x104, then the third pop falls through to sequential. `ras_empty` = 1 after the second pop.
- **Reset mid-run and wrap:** at `pc` = 0xFFFF_FFFC, step → 0x0. Assert `rst` asynchronously mid-cycle → `pc` = `RESET_VECTOR` immediately and `ras_empty` = 1.
